// File: rtl/kronos_if_pkg.sv
// Shared types and constants for the Kronos instruction fetch stage.
package kronos_if_pkg;

  localparam logic [31:0] KRONOS_BOOT_ADDR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } pipeIFID_t;

  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/kronos_if_if.sv
// Fetch-stage bus bundle: instruction memory read port, IF/ID handshake and redirect.
interface kronos_if_if;
  import kronos_if_pkg::*;

  // instr_req/instr_ack: the read completes in the cycle both are high; req and addr hold until then.
  // fetch_vld/fetch_rdy: a transfer happens in every cycle both are high; nothing else moves data.
  logic [31:0]  instr_addr;
  logic         instr_req;
  logic [31:0]  instr_data;
  logic         instr_ack;
  pipeIFID_t    fetch;
  logic         fetch_vld;
  logic         fetch_rdy;
  logic         branch;
  logic [31:0]  branch_target;
  fetch_state_e dbg_state;

  modport master (
    output instr_addr, instr_req, fetch, fetch_vld, dbg_state,
    input  instr_data, instr_ack, fetch_rdy, branch, branch_target
  );

  modport slave (
    input  instr_addr, instr_req, fetch, fetch_vld, dbg_state,
    output instr_data, instr_ack, fetch_rdy, branch, branch_target
  );

endinterface

// File: rtl/kronos_if_fetch_fifo.sv
// Two-entry {pc, ir} buffer; slot0 is always the registered head.
module kronos_fetch_fifo
  import kronos_if_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       push_i,
  input  pipeIFID_t  din_i,
  input  logic       pop_i,
  output pipeIFID_t  head_o,
  output logic       vld_o,
  output logic [1:0] count_o
);

  pipeIFID_t  slot0_q, slot0_d;
  pipeIFID_t  slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       do_pop;

  assign do_pop = pop_i & (count_q != 2'd0);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (clear_i) begin
      count_d = 2'd0;
    end else if (push_i && do_pop) begin
      // Occupancy is unchanged; the new entry lands behind whatever survives the pop.
      if (count_q == 2'd1) begin
        slot0_d = din_i;
      end else begin
        slot0_d = slot1_q;
        slot1_d = din_i;
      end
    end else if (push_i && count_q != 2'd2) begin
      if (count_q == 2'd0) slot0_d = din_i;
      else                 slot1_d = din_i;
      count_d = count_q + 2'd1;
    end else if (do_pop) begin
      slot0_d = slot1_q;
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 2'd0;
    else     count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign head_o  = slot0_q;
  assign vld_o   = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/kronos_if.sv
// Kronos instruction fetch: owns the PC, issues word reads, buffers two instructions.
module kronos_if
  import kronos_if_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = KRONOS_BOOT_ADDR
)(
  input  logic      clk,
  input  logic      rst,
  kronos_if_if.master bus
);

  localparam logic [0:0] S_FETCH   = 1'b0;
  localparam logic [0:0] S_DISCARD = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        out_q, out_d;

  logic [1:0]  occ;
  logic        head_vld;
  pipeIFID_t   head;
  logic        pop, issue, req, ack, push;
  logic [31:0] req_addr;

  assign pop = head_vld & bus.fetch_rdy;

  // Fresh reads only start in FETCH with nothing in flight; a redirect cycle never
  // starts one, so the next request already carries the new target.
  assign issue    = (state_q == S_FETCH) & ~out_q & ~bus.branch & ((occ != 2'd2) | pop);
  assign req      = ~rst & (out_q | issue);
  assign req_addr = out_q ? addr_q : pc_q;
  assign ack      = req & bus.instr_ack;
  assign push     = ack & (state_q == S_FETCH) & ~bus.branch;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = req & ~ack;
    addr_d  = req_addr;
    if (push) pc_d = pc_q + 32'd4;
    if (state_q == S_DISCARD && ack) state_d = S_FETCH;
    if (bus.branch) begin
      pc_d    = word_align(bus.branch_target);
      state_d = (req & ~ack) ? S_DISCARD : S_FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= word_align(BOOT_ADDR);
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  kronos_fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.branch),
    .push_i  (push),
    .din_i   ('{pc: req_addr, ir: bus.instr_data}),
    .pop_i   (pop),
    .head_o  (head),
    .vld_o   (head_vld),
    .count_o (occ)
  );

  assign bus.instr_addr = req_addr;
  assign bus.instr_req  = req;
  assign bus.fetch      = head;
  assign bus.fetch_vld  = head_vld;
  assign bus.dbg_state  = fetch_state_e'(state_q);

endmodule

// File: tb/tb_kronos_if.sv
// Bench for kronos_if: memory model, directed timing checks, random redirect/backpressure scoreboard.
module tb_kronos_if;
  import kronos_if_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] IR_K = 32'hA5A5_0000;

  logic clk, rst;
  kronos_if_if bus();

  kronos_if #(.BOOT_ADDR(BOOT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int pop_cnt = 0;
  int lat_mode = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    cyc();
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  // Reference stream: after reset or redirect, the decode side sees consecutive words from the start address.
  task automatic reload(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = {start[31:2], 2'b00};
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  always @(posedge clk) begin
    if (rst)             reload(BOOT);
    else if (bus.branch) reload(bus.branch_target);
  end

  // memory: per-request wait of lat_mode cycles (random 0..3 when negative), data = addr ^ IR_K
  initial begin
    int wait_cnt;
    int cur_lat;
    wait_cnt = 0;
    cur_lat = 0;
    bus.instr_ack = 1'b0;
    bus.instr_data = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.instr_req === 1'b1) begin
        if (wait_cnt == 0) cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        if (wait_cnt >= cur_lat) begin
          bus.instr_ack = 1'b1;
          bus.instr_data = bus.instr_addr ^ IR_K;
          wait_cnt = 0;
        end else begin
          bus.instr_ack = 1'b0;
          bus.instr_data = $urandom;
          wait_cnt++;
        end
      end else begin
        bus.instr_ack = 1'b0;
        bus.instr_data = $urandom;
        wait_cnt = 0;
      end
    end
  end

  // monitor: pops checked against the expected stream, plus bus stability rules
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst === 1'b0) begin
      if (bus.fetch_vld === 1'b1 && bus.fetch_rdy === 1'b1) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          chk("exp_queue_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("fetch_pc", bus.fetch.pc, e);
          chk("fetch_ir", bus.fetch.ir, e ^ IR_K);
        end
      end
      if (prev_req && !prev_ack) begin
        chk("req_held", {31'd0, bus.instr_req}, 32'd1);
        chk("addr_held", bus.instr_addr, prev_addr);
      end
      if (bus.instr_req === 1'b1) chk("addr_align", {30'd0, bus.instr_addr[1:0]}, 32'd0);
    end
    prev_req  = (rst === 1'b0) && (bus.instr_req === 1'b1);
    prev_ack  = (bus.instr_ack === 1'b1);
    prev_addr = bus.instr_addr;
  end

  // stimulus
  initial begin
    int n0;
    int found;
    rst = 1'b1;
    bus.fetch_rdy = 1'b1;
    bus.branch = 1'b0;
    bus.branch_target = 32'h0;
    lat_mode = 0;

    // reset values and zero-wait streaming
    @(negedge clk);
    chk("rst_vld", {31'd0, bus.fetch_vld}, 32'd0);
    chk("rst_req", {31'd0, bus.instr_req}, 32'd0);
    chk("rst_state", {31'd0, bus.dbg_state}, {31'd0, FETCH});
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("c1_req", {31'd0, bus.instr_req}, 32'd1);
    chk("c1_addr", bus.instr_addr, BOOT);
    chk("c1_vld", {31'd0, bus.fetch_vld}, 32'd0);
    @(negedge clk);
    chk("c2_vld", {31'd0, bus.fetch_vld}, 32'd1);
    chk("c2_pc", bus.fetch.pc, BOOT);
    cyc();
    n0 = pop_cnt;
    repeat (20) cyc();
    chk("zero_wait_rate", pop_cnt - n0, 32'd20);

    // 3-cycle memory wait: one instruction every 4 cycles
    lat_mode = 3;
    repeat (8) cyc();
    n0 = pop_cnt;
    repeat (40) cyc();
    chk("slow_mem_rate", pop_cnt - n0, 32'd10);

    // backpressure: two held, request stops, then drains in order
    lat_mode = 0;
    bus.fetch_rdy = 1'b0;
    do_reset(1);
    repeat (10) cyc();
    @(negedge clk);
    chk("bp_req", {31'd0, bus.instr_req}, 32'd0);
    chk("bp_vld", {31'd0, bus.fetch_vld}, 32'd1);
    chk("bp_head", bus.fetch.pc, 32'h0);
    cyc();
    bus.fetch_rdy = 1'b1;
    n0 = pop_cnt;
    repeat (6) cyc();
    chk("bp_drain", pop_cnt - n0, 32'd6);

    // redirect while the read of 0x8 waits
    lat_mode = 2;
    do_reset(1);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      if (bus.instr_req === 1'b1 && bus.instr_addr == 32'h8) found = 1;
    end
    chk("br1_found", found, 32'd1);
    cyc();
    bus.branch = 1'b1;
    bus.branch_target = 32'h100;
    cyc();
    bus.branch = 1'b0;
    @(negedge clk);
    chk("br1_discard_state", {31'd0, bus.dbg_state}, {31'd0, DISCARD});
    chk("br1_old_addr", bus.instr_addr, 32'h8);
    chk("br1_vld_low_a", {31'd0, bus.fetch_vld}, 32'd0);
    cyc();
    @(negedge clk);
    chk("br1_new_addr", bus.instr_addr, 32'h100);
    chk("br1_vld_low_b", {31'd0, bus.fetch_vld}, 32'd0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.fetch_vld === 1'b1) found = 1;
    end
    chk("br1_first_pc", bus.fetch.pc, 32'h100);

    // redirect to a misaligned target in the ack cycle
    lat_mode = 1;
    do_reset(1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.instr_req === 1'b1 && bus.instr_ack === 1'b0) found = 1;
    end
    chk("br2_found", found, 32'd1);
    cyc();
    bus.branch = 1'b1;
    bus.branch_target = 32'h203;
    @(negedge clk);
    chk("br2_ack_same_cycle", {31'd0, bus.instr_ack}, 32'd1);
    cyc();
    bus.branch = 1'b0;
    @(negedge clk);
    chk("br2_addr", bus.instr_addr, 32'h200);
    chk("br2_req", {31'd0, bus.instr_req}, 32'd1);
    chk("br2_state", {31'd0, bus.dbg_state}, {31'd0, FETCH});
    chk("br2_vld", {31'd0, bus.fetch_vld}, 32'd0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (bus.fetch_vld === 1'b1) found = 1;
    end
    chk("br2_first_pc", bus.fetch.pc, 32'h200);

    // reset in the middle of a pending read with the buffer occupied
    lat_mode = 3;
    bus.fetch_rdy = 1'b0;
    do_reset(1);
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (bus.fetch_vld === 1'b1 && bus.instr_req === 1'b1) found = 1;
    end
    chk("rst_mid_found", found, 32'd1);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req0", {31'd0, bus.instr_req}, 32'd0);
    cyc();
    @(negedge clk);
    chk("rst_mid_vld", {31'd0, bus.fetch_vld}, 32'd0);
    chk("rst_mid_req1", {31'd0, bus.instr_req}, 32'd0);
    cyc();
    rst = 1'b0;
    lat_mode = 0;
    bus.fetch_rdy = 1'b1;
    n0 = pop_cnt;
    @(negedge clk);
    chk("rst_mid_restart_req", {31'd0, bus.instr_req}, 32'd1);
    chk("rst_mid_restart_addr", bus.instr_addr, BOOT);
    repeat (10) cyc();
    chk("rst_mid_stream", pop_cnt - n0, 32'd9);

    // random backpressure, latency, redirects and occasional reset
    lat_mode = -1;
    n0 = pop_cnt;
    for (int i = 0; i < 1500; i++) begin
      cyc();
      bus.fetch_rdy = ($urandom_range(0, 3) != 0);
      bus.branch = ($urandom_range(0, 19) == 0);
      bus.branch_target = $urandom_range(0, 32'hFFFF);
      rst = ($urandom_range(0, 199) == 0);
    end
    cyc();
    rst = 1'b0;
    bus.branch = 1'b0;
    bus.fetch_rdy = 1'b1;
    repeat (10) cyc();
    chk("random_liveness", {31'd0, (pop_cnt - n0) > 150}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kronos_if.md
# kronos_IF

Instruction fetch stage of the Kronos RV32I core. It owns the program counter, issues word reads on the instruction memory bus, buffers up to two returned instructions, and presents them with their PC to the decode stage over a valid/ready handshake. A redirect from the execute/writeback side (taken branch, jump, trap, fence.i) flushes the buffer, discards any in-flight read, and restarts fetch at the new target.

## Interface

Parameters:
- BOOT_ADDR, 32'h0, first fetch address after reset (word aligned).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- instr_addr  out  32  instruction read address; bits [1:0] always 2'b00
- instr_req  out  1  read request; held until instr_ack
- instr_data  in  32  read data, valid on instr_ack
- instr_ack  in  1  read complete; may assert in the same cycle as instr_req
- fetch  out  pipeIFID_t  {pc, ir} of the head instruction
- fetch_vld  out  1  fetch holds a valid instruction
- fetch_rdy  in  1  decode accepts fetch this cycle
- branch  in  1  redirect strobe, single cycle
- branch_target  in  32  redirect address, sampled when branch=1

## Operation

- State:
  - pc: next address to request.
  - state ∈ {FETCH, DISCARD}.
  - outstanding (0/1).
  - 2-entry FIFO of {pc, ir}.
- Bus rules:
  - instr_req and instr_addr stay stable from assertion until the instr_ack cycle.
  - At most one read is outstanding.
  - A read is never aborted.
- Issue rule (FETCH only):
  - New request when occupancy + outstanding − pop < 2, where pop = fetch_vld & fetch_rdy.
  - On issue, instr_addr = pc; pc advances by 4 when the request is accepted (instr_ack).
  - Back-to-back issue: the cycle after an ack, a new request may start without an idle cycle.
- Return: on instr_ack in FETCH, push {instr_addr, instr_data} into the FIFO.
- Output: fetch/fetch_vld are the FIFO head, registered. Pop on fetch_vld & fetch_rdy.
- Redirect (branch=1):
  - FIFO cleared.
  - pc ← {branch_target[31:2], 2'b00}.
  - If a request is outstanding and not acked this cycle → DISCARD. Otherwise stay in FETCH.
  - A pop in the same cycle is still a completed handshake. Decode discards it through its own flush.
- DISCARD:
  - Keep instr_req high with the old address.
  - On instr_ack, drop the data and go to FETCH.
  - A second branch while in DISCARD overwrites pc and stays in DISCARD.
- Simultaneous events:
  - Ack and branch in the same cycle: data dropped, state FETCH, new request issued the next cycle.
  - Push and pop in the same cycle with the FIFO full: legal. Occupancy stays 2.
- Misaligned branch_target: low bits are silently cleared. Alignment faults are flagged upstream of the redirect, not here.
- Fetch does not decode instructions.

## Timing

- Reset values:
  - fetch_vld=0, instr_req=0, state=FETCH, outstanding=0, FIFO empty, pc=BOOT_ADDR.
  - fetch contents are don't-care.
- First cycle after rst deasserts: instr_req=1, instr_addr=BOOT_ADDR.
- Latency: instr_ack at cycle N → fetch_vld=1 at N+1.
- Throughput with a zero-wait memory (ack with req) and fetch_rdy=1: one instruction per cycle sustained.
- Redirect at cycle N with no in-flight read: fetch_vld=0 at N+1; instr_req with target at N+1; first target instruction at N+2 at the earliest.
- Backpressure: with fetch_rdy=0, at most two instructions are held. instr_req drops once the FIFO plus the outstanding read reaches 2.
- rst asserted mid-transaction: all state returns to reset values the next cycle. The memory side must tolerate a dropped request.

## Structure

- pipeIFID_t already exists in kronos_types; reuse it unchanged.
- Add BOOT_ADDR default constant and fetch-state enum {FETCH, DISCARD} to kronos_types.
- One natural sub-module: kronos_fetch_fifo, a 2-entry FIFO of pipeIFID_t with push/pop/clear, occupancy count, and simultaneous push+pop when full.

## Test plan

- Reset, zero-wait memory returning IR=addr^32'hA5A5_0000, fetch_rdy=1 → fetch_vld at cycle 2, pcs 0x0, 0x4, 0x8… one per cycle, ir matches.
- Memory ack delayed 3 cycles per read → instr_addr/instr_req stable until ack, fetch_vld pulses once per 4 cycles, no duplicates.
- fetch_rdy=0 for 10 cycles → FIFO holds pcs 0x0 and 0x4, instr_req low; on release, 0x0, 0x4, 0x8 in order, no loss.
- branch to 0x100 while the read of 0x8 is pending (ack 2 cycles later) → 0x8 data dropped, next fetch pc=0x100, fetch_vld low in between.
- branch to 0x203 in the same cycle as instr_ack → instr_addr=0x200 next cycle, acked data discarded.
- rst asserted while instr_req high and FIFO full → next cycle fetch_vld=0, instr_req=0; then restart at BOOT_ADDR.
